// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches 16-bit words over req/ack and hands them to the decoder.
// Latency: ack and ready in their earliest cycles give one instruction every 2 cycles.
// Backpressure: while instr_valid is held the unit stops fetching; redirects squash or cancel in-flight work.
module instr_fetch_unit #(
   parameter int                 ADDR_W   = 6,
   parameter int                 INSTR_W  = 16,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst,
   output logic                imem_req,
   output logic [ADDR_W-1:0]   imem_addr,
   input  logic                imem_ack,
   input  logic [INSTR_W-1:0]  imem_rdata,
   output logic [INSTR_W-1:0]  instr,
   output logic                instr_valid,
   input  logic                instr_ready,
   output logic [ADDR_W-1:0]   instr_pc,
   input  logic                redirect,
   input  logic [ADDR_W-1:0]   redirect_target,
   output logic                halted
);

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_HOLD   = 2'd1,
      S_HALTED = 2'd2
   } state_e;

   localparam logic [4:0] OP_HALT = 5'b11111;

   state_e               state_q, state_d;
   logic [ADDR_W-1:0]    pc_q, pc_d;
   logic [ADDR_W-1:0]    pending_pc_q, pending_pc_d;
   logic                 squash_q, squash_d;
   logic                 imem_req_q, imem_req_d;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic                 instr_valid_q, instr_valid_d;
   logic [ADDR_W-1:0]    instr_pc_q, instr_pc_d;
   logic                 halted_q, halted_d;
   logic                 ack_fire;

   // An ack only counts while our own request is up.
   assign ack_fire = imem_req_q & imem_ack;

   // State register; reset abandons any outstanding request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_FETCH;
         pc_q          <= RESET_PC;
         pending_pc_q  <= RESET_PC;
         squash_q      <= 1'b0;
         imem_req_q    <= 1'b0;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         instr_pc_q    <= '0;
         halted_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         pending_pc_q  <= pending_pc_d;
         squash_q      <= squash_d;
         imem_req_q    <= imem_req_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         instr_pc_q    <= instr_pc_d;
         halted_q      <= halted_d;
      end
   end

   // Next-state logic: fetch, hold for the decoder, or stop on a consumed HALT.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      pending_pc_d  = pending_pc_q;
      squash_d      = squash_q;
      imem_req_d    = imem_req_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      instr_pc_d    = instr_pc_q;
      halted_d      = halted_q;

      case (state_q)
         S_FETCH: begin
            imem_req_d = 1'b1;
            if (ack_fire) begin
               // Request completes; req drops for one cycle whatever happens to the data.
               imem_req_d = 1'b0;
               if (squash_q) begin
                  squash_d = 1'b0;
                  pc_d     = redirect ? redirect_target : pending_pc_q;
               end else if (redirect) begin
                  pc_d = redirect_target;
               end else begin
                  instr_d       = imem_rdata;
                  instr_pc_d    = pc_q;
                  pc_d          = pc_q + ADDR_W'(1);
                  instr_valid_d = 1'b1;
                  state_d       = S_HOLD;
               end
            end else if (redirect) begin
               // imem_addr must stay put under an open request, so park the target.
               if (imem_req_q) begin
                  squash_d     = 1'b1;
                  pending_pc_d = redirect_target;
               end else begin
                  pc_d = redirect_target;
               end
            end
         end
         S_HOLD: begin
            if (redirect) begin
               // Redirect beats a same-cycle accept, including of a held HALT.
               pc_d          = redirect_target;
               instr_valid_d = 1'b0;
               imem_req_d    = 1'b1;
               state_d       = S_FETCH;
            end else if (instr_ready) begin
               instr_valid_d = 1'b0;
               if (instr_q[INSTR_W-1 -: 5] == OP_HALT) begin
                  halted_d = 1'b1;
                  state_d  = S_HALTED;
               end else begin
                  imem_req_d = 1'b1;
                  state_d    = S_FETCH;
               end
            end
         end
         S_HALTED: begin
            imem_req_d    = 1'b0;
            instr_valid_d = 1'b0;
            halted_d      = 1'b1;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   assign imem_req    = imem_req_q;
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign instr_pc    = instr_pc_q;
   assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by randomized traffic.
// Reference tracks the expected instruction stream (next PC to present, halt status).
// Memory responder acks after a configurable latency; decoder ready and redirects are driven per cycle.
module tb_instr_fetch_unit;
   localparam int AW = 6;
   localparam int IW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          imem_req, imem_ack, instr_valid, instr_ready, redirect, halted;
   logic [AW-1:0] imem_addr, instr_pc, redirect_target;
   logic [IW-1:0] imem_rdata, instr;

   always #5 clk = ~clk;

   instr_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(6'd0)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_pc(instr_pc),
      .redirect(redirect), .redirect_target(redirect_target), .halted(halted)
   );

   logic [IW-1:0] mem [64];
   int n_checks = 0;
   int n_fail   = 0;

   // stimulus controls
   int          ready_mode = 1;   // 0: low, 1: high, 2: random
   int          lat = 0;          // cycles of req before ack
   bit          lat_rand = 1'b0;
   int          age = 0;
   int          redir_pct = 0;
   bit          redir_arm = 1'b0;
   logic [5:0]  redir_tgt = '0;

   // reference model state
   logic [5:0]  exp_pc = '0;
   bit          halted_exp = 1'b0;
   bit          prev_valid, prev_req, prev_ack, prev_taken;
   logic [15:0] prev_instr;
   logic [5:0]  prev_pc, prev_addr;
   int          stall = 0;
   int          cyc = 0;
   int          log_pc[$];
   logic [15:0] log_instr[$];
   int          log_cyc[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_clear();
      exp_pc = '0; halted_exp = 1'b0;
      prev_valid = 1'b0; prev_req = 1'b0; prev_ack = 1'b0; prev_taken = 1'b0;
      prev_instr = '0; prev_pc = '0; prev_addr = '0;
      stall = 0; age = 0;
   endtask

   // Drive inputs for the coming edge, check current outputs, advance the model, step one cycle.
   task automatic tick();
      imem_ack   = imem_req && (age >= lat);
      imem_rdata = imem_ack ? mem[imem_addr] : 16'($urandom);
      case (ready_mode)
         0:       instr_ready = 1'b0;
         1:       instr_ready = 1'b1;
         default: instr_ready = 1'($urandom_range(0, 1));
      endcase
      redirect        = redir_arm || (int'($urandom_range(0, 99)) < redir_pct);
      redirect_target = redir_arm ? redir_tgt : 6'($urandom_range(0, 63));
      redir_arm       = 1'b0;

      if (halted_exp) begin
         check("halted_hi", halted, 1);
         check("halted_req", imem_req, 0);
         check("halted_valid", instr_valid, 0);
      end else begin
         check("halted_lo", halted, 0);
         if (instr_valid && !prev_valid) begin
            check("present_pc", instr_pc, exp_pc);
            check("present_instr", instr, mem[exp_pc]);
            log_pc.push_back(int'(instr_pc));
            log_instr.push_back(instr);
            log_cyc.push_back(cyc);
         end
         if (instr_valid && prev_valid) begin
            check("hold_instr", instr, prev_instr);
            check("hold_pc", instr_pc, prev_pc);
         end
         check("liveness", stall > 16, 0);
      end
      if (prev_taken) check("valid_drop", instr_valid, 0);
      if (prev_req && !prev_ack && imem_req) check("addr_stable", imem_addr, prev_addr);

      prev_taken = !halted_exp && instr_valid && (instr_ready || redirect);
      if (!halted_exp) begin
         if (redirect) begin
            exp_pc = redirect_target;
         end else if (instr_valid && instr_ready) begin
            if (mem[exp_pc][15:11] == 5'b11111) halted_exp = 1'b1;
            exp_pc = exp_pc + 6'd1;
         end
      end
      if (halted_exp || instr_valid || redirect) stall = 0;
      else stall++;
      prev_valid = instr_valid; prev_instr = instr; prev_pc = instr_pc;
      prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
      if (imem_req && !imem_ack) age++;
      else begin
         age = 0;
         if (lat_rand) lat = $urandom_range(0, 3);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
      redirect_target = '0; imem_rdata = '0; redir_arm = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      cyc += n;
      rst = 1'b0;
      model_clear();
      check("rst_req", imem_req, 0);
      check("rst_valid", instr_valid, 0);
      check("rst_halted", halted, 0);
      check("rst_instr", instr, 0);
      check("rst_instr_pc", instr_pc, 0);
      check("rst_addr", imem_addr, 0);
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!instr_valid && n < 30) begin
         tick();
         n++;
      end
      check("wait_valid", instr_valid, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [5:0]  pc0;
      logic [15:0] w;
      int          n;
      for (int i = 0; i < 64; i++) mem[i] = 16'h0800 + 16'(i);
      model_clear();
      do_reset(2);

      // back-to-back: ack with req, ready high
      ready_mode = 1; lat = 0; lat_rand = 1'b0;
      log_pc.delete(); log_instr.delete(); log_cyc.delete();
      repeat (7) tick();
      check("stream_len", log_pc.size() >= 3, 1);
      if (log_pc.size() >= 3) begin
         for (int i = 0; i < 3; i++) begin
            check("stream_pc", log_pc[i], i);
            check("stream_instr", log_instr[i], 32'h0800 + i);
         end
         check("stream_gap1", log_cyc[1] - log_cyc[0], 2);
         check("stream_gap2", log_cyc[2] - log_cyc[1], 2);
      end

      // backpressure: 5 cycles of ready low while holding
      ready_mode = 0;
      wait_valid();
      pc0 = instr_pc;
      repeat (5) begin
         check("bp_req", imem_req, 0);
         check("bp_valid", instr_valid, 1);
         tick();
      end
      ready_mode = 1;
      tick();
      check("bp_next_req", imem_req, 1);
      check("bp_next_addr", imem_addr, pc0 + 6'd1);

      // redirect in HOLD with ready high
      wait_valid();
      redir_arm = 1'b1; redir_tgt = 6'd40;
      tick();
      check("rdh_valid", instr_valid, 0);
      check("rdh_req", imem_req, 1);
      check("rdh_addr", imem_addr, 40);
      wait_valid();
      check("rdh_pc", instr_pc, 40);

      // redirect while a slow fetch to address 5 is outstanding
      lat = 3;
      redir_arm = 1'b1; redir_tgt = 6'd5;
      tick();
      for (int k = 0; k < 8; k++) begin
         if (!imem_req) break;
         check("sq_addr", imem_addr, 5);
         if (k == 1) begin
            redir_arm = 1'b1; redir_tgt = 6'd10;
         end
         tick();
      end
      check("sq_drop_req", imem_req, 0);
      check("sq_no_valid", instr_valid, 0);
      tick();
      check("sq_refetch_req", imem_req, 1);
      check("sq_refetch_addr", imem_addr, 10);
      wait_valid();
      check("sq_pc", instr_pc, 10);

      // wrap 63 -> 0, then HALT at 7
      lat = 0;
      mem[7] = 16'hF800;
      redir_arm = 1'b1; redir_tgt = 6'd62;
      tick();
      log_pc.delete(); log_instr.delete(); log_cyc.delete();
      n = 0;
      while (!halted_exp && n < 60) begin
         tick();
         n++;
      end
      check("halt_log_len", log_pc.size(), 10);
      if (log_pc.size() == 10) begin
         check("wrap_63", log_pc[1], 63);
         check("wrap_0", log_pc[2], 0);
         check("halt_pc", log_pc[9], 7);
         check("halt_word", log_instr[9], 16'hF800);
      end
      check("halt_flag", halted, 1);
      check("halt_req", imem_req, 0);
      redir_arm = 1'b1; redir_tgt = 6'd20;
      repeat (4) tick();
      check("halt_after_redir", halted, 1);
      check("halt_after_redir_req", imem_req, 0);

      // reset while halted, then reset with an ack pending
      do_reset(1);
      wait_valid();
      check("restart_pc", instr_pc, 0);
      check("restart_instr", instr, 16'h0800);
      lat = 5;
      n = 0;
      while (!imem_req && n < 10) begin
         tick();
         n++;
      end
      tick();
      do_reset(2);
      mem[7] = 16'h0807;

      // randomized traffic
      for (int i = 0; i < 64; i++) begin
         w = 16'($urandom);
         if ($urandom_range(0, 11) == 0) w[15:11] = 5'b11111;
         else if (w[15:11] == 5'b11111) w[15] = 1'b0;
         mem[i] = w;
      end
      ready_mode = 2; lat_rand = 1'b1; lat = 1; redir_pct = 6;
      for (int i = 0; i < 3000; i++) begin
         if (halted_exp && $urandom_range(0, 3) == 0) do_reset(int'($urandom_range(1, 2)));
         else if ($urandom_range(0, 399) == 0) do_reset(1);
         else tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
